// File: rtl/atp_payment_fsm_multi_pkg.sv
// Shared types and constants for the multi-channel ATP payment FSM.
// The optional ATP_TXN_STATS_EN build uses sat_inc16 for its counters.
package atp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BILL,
    SELECT,
    WAIT_TENDER,
    VERIFY,
    APPLY,
    DONE,
    DISCONNECT
  } state_t;

  localparam int CH_CHEQUE = 0;
  localparam int CH_DD     = 1;
  localparam int CH_CARD   = 2;
  localparam int CH_CASH   = 3;

  localparam logic [3:0] DEF_CASH_MASK  = 4'b1000;
  localparam logic [3:0] DEF_CH_EN_MASK = 4'b1111;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/atp_watchdog.sv
// Inactivity counter: runs while en, restarts on clr or when disabled,
// and flags expire on the TIMEOUT_CYC-th consecutive idle cycle.
module atp_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // A handshake in the expiring cycle takes priority over the timeout.
  assign expire = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (!en || clr || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/atp_payment_fsm_multi.sv
// Multi-tender ATP payment FSM with bank verify handshake and idle watchdog.
// Define ATP_TXN_STATS_EN to add saturating ok/fail/reject counters.
module atp_payment_fsm_multi
  import atp_pkg::*;
#(
  parameter int AMT_W       = 8,
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int BARCODE_W   = 4,
  parameter logic [NUM_CH-1:0] CASH_MASK  = DEF_CASH_MASK,
  parameter logic [NUM_CH-1:0] CH_EN_MASK = DEF_CH_EN_MASK,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start_payment,
  input  logic                    bill_valid,
  input  logic [BARCODE_W-1:0]    barcode,
  input  logic [AMT_W-1:0]        bill_amount,
  input  logic                    choice_valid,
  input  logic [CH_W-1:0]         choice,
  input  logic [NUM_CH-1:0]       pay_valid,
  input  logic [NUM_CH*AMT_W-1:0] pay_amount,
  output logic                    verify_req,
  input  logic                    verify_ack,
  input  logic                    verify_ok,
  output logic [BARCODE_W-1:0]    barcode_latched,
  output logic [AMT_W-1:0]        remaining_amount,
  output logic                    change_valid,
  output logic [AMT_W-1:0]        change_amount,
  output logic                    reject,
  output logic                    payment_complete,
  output logic                    line_disconnected,
  output logic                    busy,
  output state_t                  state_dbg
`ifdef ATP_TXN_STATS_EN
  ,
  output logic [15:0]             txn_ok_count,
  output logic [15:0]             txn_fail_count,
  output logic [15:0]             reject_count
`endif
);

  state_t            state;
  logic [CH_W-1:0]   sel_q;
  logic [AMT_W-1:0]  tender_q;
  logic [AMT_W-1:0]  cur_pay;
  logic              sel_cash;
  logic              choice_ok;
  logic              hs;
  logic              wd_en;
  logic              wd_expire;

  always_comb begin
    cur_pay   = pay_amount[sel_q*AMT_W +: AMT_W];
    sel_cash  = CASH_MASK[sel_q];
    choice_ok = 1'b0;
    if (int'(choice) < NUM_CH) choice_ok = CH_EN_MASK[choice];
  end

  // Handshakes: bill_valid, choice_valid, pay_valid[sel] and verify_ack are
  // single-cycle strobes with no ready; each is consumed only in the state
  // that waits for it and ignored everywhere else.
  always_comb begin
    hs = 1'b0;
    case (state)
      WAIT_BILL:   hs = bill_valid;
      SELECT:      hs = choice_valid;
      WAIT_TENDER: hs = pay_valid[sel_q];
      VERIFY:      hs = verify_ack;
      default:     hs = 1'b0;
    endcase
  end

  assign wd_en = (state == WAIT_BILL) || (state == SELECT) ||
                 (state == WAIT_TENDER) || (state == VERIFY);

  atp_watchdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (wd_en),
    .clr     (hs),
    .expire  (wd_expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      sel_q             <= '0;
      tender_q          <= '0;
      barcode_latched   <= '0;
      remaining_amount  <= '0;
      change_amount     <= '0;
      change_valid      <= 1'b0;
      reject            <= 1'b0;
      payment_complete  <= 1'b0;
      line_disconnected <= 1'b0;
      verify_req        <= 1'b0;
    end else begin
      change_valid      <= 1'b0;
      reject            <= 1'b0;
      payment_complete  <= 1'b0;
      line_disconnected <= 1'b0;
      if (wd_expire) begin
        state             <= IDLE;
        line_disconnected <= 1'b1;
        remaining_amount  <= '0;
        barcode_latched   <= '0;
        verify_req        <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_payment) state <= WAIT_BILL;
          WAIT_BILL: begin
            if (bill_valid) begin
              barcode_latched  <= barcode;
              remaining_amount <= bill_amount;
              if (bill_amount == '0) begin
                state            <= DONE;
                payment_complete <= 1'b1;
              end else begin
                state <= SELECT;
              end
            end
          end
          SELECT: begin
            if (choice_valid) begin
              if (choice_ok) begin
                sel_q <= choice;
                state <= WAIT_TENDER;
              end else begin
                reject <= 1'b1;
              end
            end
          end
          WAIT_TENDER: begin
            if (pay_valid[sel_q]) begin
              tender_q <= cur_pay;
              if (cur_pay == '0) begin
                reject <= 1'b1;
                state  <= SELECT;
              end else if (sel_cash) begin
                state <= APPLY;
              end else begin
                verify_req <= 1'b1;
                state      <= VERIFY;
              end
            end
          end
          VERIFY: begin
            if (verify_ack) begin
              verify_req <= 1'b0;
              if (verify_ok) begin
                state <= APPLY;
              end else begin
                reject <= 1'b1;
                state  <= SELECT;
              end
            end
          end
          APPLY: begin
            // Every subtract below is guarded by the compare, so no wrap.
            if (tender_q < remaining_amount) begin
              remaining_amount <= remaining_amount - tender_q;
              state            <= SELECT;
            end else if (tender_q == remaining_amount) begin
              remaining_amount <= '0;
              payment_complete <= 1'b1;
              state            <= DONE;
            end else if (sel_cash) begin
              change_amount    <= tender_q - remaining_amount;
              change_valid     <= 1'b1;
              remaining_amount <= '0;
              payment_complete <= 1'b1;
              state            <= DONE;
            end else begin
              reject <= 1'b1;
              state  <= SELECT;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

`ifdef ATP_TXN_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txn_ok_count   <= '0;
      txn_fail_count <= '0;
      reject_count   <= '0;
    end else begin
      if (payment_complete)  txn_ok_count   <= sat_inc16(txn_ok_count);
      if (line_disconnected) txn_fail_count <= sat_inc16(txn_fail_count);
      if (reject)            reject_count   <= sat_inc16(reject_count);
    end
  end
`endif

endmodule
